// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl
//  Description : Interrupt aggregator between peripheral interrupt lines and
//                the core interrupt entry path. Latches and masks requests,
//                picks the lowest-numbered enabled pending source, raises a
//                single request with its ID, and tracks one in-service
//                interrupt until software writes a completion to CLAIM.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_SRC   : number of interrupt sources (1..32); bit i of each register
//                maps to source i. Source 0 is the timer level interrupt.
//  Build option
//    IRQ_CTRL_SYNC_EN : when defined, every irq_src_i bit passes through a
//                2-flop synchronizer before edge/level detection, adding two
//                cycles of request latency (4 cycles instead of 2).
//  Ports
//    clk        in   system clock
//    rstn       in   asynchronous active-low reset
//    data_i     in   [31:0] register write data
//    addr_i     in   [31:0] register address, only [3:0] decoded
//    we_i       in   register write enable
//    data_o     out  [31:0] register read data, combinational from addr_i
//    irq_src_i  in   [NUM_SRC-1:0] raw interrupt lines (clk domain)
//    int_ack_i  in   core accepts the current request (1-cycle pulse)
//    int_o      out  interrupt request to the core
//    int_id_o   out  [4:0] ID of the requested / in-service source
//  Register map (addr_i[3:0])
//    0x0 ENABLE  RW
//    0x4 PENDING RO for level sources, write-1-to-clear for edge sources
//    0x8 TRIGGER RW  1 = rising edge, 0 = level
//    0xC CLAIM   read {27'b0,id} while in service, else 0; write = completion
// ============================================================================
module irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [31:0]        data_i,
    input  logic [31:0]        addr_i,
    input  logic               we_i,
    output logic [31:0]        data_o,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic               int_ack_i,
    output logic               int_o,
    output logic [4:0]         int_id_o
);

    localparam logic [3:0] c_ADDR_ENABLE  = 4'h0;
    localparam logic [3:0] c_ADDR_PENDING = 4'h4;
    localparam logic [3:0] c_ADDR_TRIGGER = 4'h8;
    localparam logic [3:0] c_ADDR_CLAIM   = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [4:0]         r_id;
    logic [4:0]         w_id_nxt;
    logic               r_int_o;

    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_trigger;
    logic [NUM_SRC-1:0] r_src_q;
    logic [NUM_SRC-1:0] w_src;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_ack_sel;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_pend_nxt;

    logic [31:0]        w_en32;
    logic [31:0]        w_pend32;
    logic [31:0]        w_trig32;

    logic               w_wr_enable;
    logic               w_wr_pending;
    logic               w_wr_trigger;
    logic               w_wr_claim;
    logic               w_cand_valid;
    logic [4:0]         w_cand_id;
    logic               w_req_live;
    logic               w_ack;
    logic               w_complete;

    // Upper address bits and unused data bits are intentionally ignored.
    logic               w_unused_bus;
    assign w_unused_bus = ^{addr_i[31:4], data_i};

    // ------------------------------------------------------------------
    // Source conditioning
    // ------------------------------------------------------------------
`ifdef IRQ_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_src_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = irq_src_i;
`endif

    // ------------------------------------------------------------------
    // Register bus decode
    // ------------------------------------------------------------------
    assign w_wr_enable  = we_i && (addr_i[3:0] == c_ADDR_ENABLE);
    assign w_wr_pending = we_i && (addr_i[3:0] == c_ADDR_PENDING);
    assign w_wr_trigger = we_i && (addr_i[3:0] == c_ADDR_TRIGGER);
    assign w_wr_claim   = we_i && (addr_i[3:0] == c_ADDR_CLAIM);

    // Zero-extended 32-bit views: bits at or above NUM_SRC read as 0 and a
    // 5-bit ID can index them without range issues.
    always_comb begin
        w_en32   = '0;
        w_pend32 = '0;
        w_trig32 = '0;
        w_en32[NUM_SRC-1:0]   = r_enable;
        w_pend32[NUM_SRC-1:0] = r_pending;
        w_trig32[NUM_SRC-1:0] = r_trigger;
    end

    always_comb begin
        data_o = '0;
        case (addr_i[3:0])
            c_ADDR_ENABLE:  data_o = w_en32;
            c_ADDR_PENDING: data_o = w_pend32;
            c_ADDR_TRIGGER: data_o = w_trig32;
            c_ADDR_CLAIM:   data_o = (r_state == ST_SERVICE) ? {27'b0, r_id} : 32'b0;
            default:        data_o = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Candidate selection: lowest index wins because it is assigned last.
    // ------------------------------------------------------------------
    always_comb begin
        w_cand_valid = 1'b0;
        w_cand_id    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (r_pending[i] && r_enable[i]) begin
                w_cand_valid = 1'b1;
                w_cand_id    = 5'(i);
            end
        end
    end

    assign w_req_live = w_pend32[r_id] & w_en32[r_id];
    assign w_ack      = (r_state == ST_REQ) && int_ack_i;
    assign w_complete = (r_state == ST_SERVICE) && w_wr_claim && (data_i[4:0] == r_id);

    // ------------------------------------------------------------------
    // Pending update. Level bits follow the source; edge bits set on a rising
    // edge and clear on W1C or on ack of their ID, with set taking priority.
    // ------------------------------------------------------------------
    always_comb begin
        w_ack_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_ack_sel[i] = w_ack && (r_id == 5'(i));
        end
    end

    assign w_rise     = w_src & ~r_src_q;
    assign w_w1c      = w_wr_pending ? data_i[NUM_SRC-1:0] : '0;
    assign w_clr      = (w_ack_sel | w_w1c) & r_trigger;
    assign w_pend_nxt = (w_src & ~r_trigger)
                      | (r_trigger & (w_rise | (r_pending & ~w_clr)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_enable  <= '0;
            r_trigger <= '0;
            r_pending <= '0;
            r_src_q   <= '0;
        end else begin
            if (w_wr_enable) begin
                r_enable <= data_i[NUM_SRC-1:0];
            end
            if (w_wr_trigger) begin
                r_trigger <= data_i[NUM_SRC-1:0];
            end
            r_pending <= w_pend_nxt;
            r_src_q   <= w_src;
        end
    end

    // ------------------------------------------------------------------
    // Request / service FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        case (r_state)
            ST_IDLE: begin
                if (w_cand_valid) begin
                    w_state_nxt = ST_REQ;
                    w_id_nxt    = w_cand_id;
                end
            end
            ST_REQ: begin
                // ID stays frozen; a lower-index arrival does not preempt.
                if (int_ack_i) begin
                    w_state_nxt = ST_SERVICE;
                end else if (!w_req_live) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                // Completions carrying a different ID are ignored.
                if (w_complete) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_id    <= '0;
            r_int_o <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_id    <= w_id_nxt;
            // Registered copy of "next state is REQ" so int_o is glitch-free
            // and tracks r_state exactly.
            r_int_o <= (w_state_nxt == ST_REQ);
        end
    end

    assign int_o    = r_int_o;
    assign int_id_o = r_id;

endmodule
`default_nettype wire
